// File: rtl/bitstream_pkg.sv
// Shared types for the bitstream expander: bundle flag encoding, expansion FSM
// states and small flag-decoding helpers.
package bitstream_pkg;

  localparam int FLAG_W    = 3;
  localparam int NUM_BYTES = 4;

  typedef enum logic [FLAG_W-1:0] {
    NONE     = 3'd0,
    PLAIN1   = 3'd1,
    PLAIN2   = 3'd2,
    PLAIN3   = 3'd3,
    INVALID  = 3'd4,
    RUN      = 3'd5,
    RUN_B4   = 3'd6,
    RUN_B4B5 = 3'd7
  } flag_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_RUN,
    ST_TAIL,
    ST_PLAIN,
    ST_MARK
  } exp_state_e;

  // Number of bytes following the run section (bit_4, then bit_5).
  function automatic logic [1:0] tail_bytes(flag_e f);
    case (f)
      RUN_B4:   return 2'd1;
      RUN_B4B5: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

  // Bundles that carry no bytes at all.
  function automatic logic is_empty_flag(flag_e f);
    return (f == NONE) || (f == INVALID);
  endfunction

endpackage

// File: rtl/bundle_fifo.sv
// Bundle storage array: one write port, one asynchronous read port.
// Pointer and occupancy control live in the owner.
module bundle_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bitstream_expander.sv
// Buffers compressed bundles and expands them (head, run of bit_2 copies,
// tail bytes) into beats of up to OUT_LANES bytes over valid/ready.
module bitstream_expander
  import bitstream_pkg::*;
#(
  parameter int BYTE_WIDTH = 8,
  parameter int RUN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int OUT_LANES  = 4
) (
  input  logic                               top_clk,
  input  logic                               top_reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [FLAG_W-1:0]                  in_flag,
  input  logic [BYTE_WIDTH-1:0]              in_bit_1,
  input  logic [BYTE_WIDTH-1:0]              in_bit_2,
  input  logic [RUN_WIDTH-1:0]               in_bit_3,
  input  logic [BYTE_WIDTH-1:0]              in_bit_4,
  input  logic [BYTE_WIDTH-1:0]              in_bit_5,
  input  logic                               in_last,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_LANES*BYTE_WIDTH-1:0]    out_data,
  output logic [$clog2(OUT_LANES+1)-1:0]     out_count,
  output logic                               out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               err_flag
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OUT_LANES + 1);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  // bytes[0]=bit_1, [1]=bit_2, [2]=bit_4, [3]=bit_5; run carries bit_3.
  typedef struct packed {
    flag_e                                flag;
    logic [NUM_BYTES-1:0][BYTE_WIDTH-1:0] bytes;
    logic [RUN_WIDTH-1:0]                 run;
    logic                                 last;
  } bundle_t;

  typedef struct packed {
    logic [OUT_LANES-1:0][BYTE_WIDTH-1:0] data;
    logic [CW-1:0]                        count;
    exp_state_e                           st;
    logic [RUN_WIDTH-1:0]                 cnt;
    logic [1:0]                           sub;
  } beat_t;

  // Skip over phases that have nothing left to emit.
  function automatic exp_state_e settle(exp_state_e st, logic [RUN_WIDTH-1:0] cnt,
                                        logic [1:0] sub, bundle_t b);
    exp_state_e s;
    s = st;
    if (s == ST_RUN && cnt == '0) s = ST_TAIL;
    if (s == ST_TAIL && sub >= tail_bytes(b.flag)) s = ST_IDLE;
    if (s == ST_PLAIN && {1'b0, sub} >= b.flag) s = ST_IDLE;
    if (s == ST_MARK) s = ST_IDLE;
    return s;
  endfunction

  // Walk the expansion from (st0, cnt0, sub0) filling lanes in order; the
  // returned state is where the next beat of the same bundle starts.
  function automatic beat_t build_beat(bundle_t b, exp_state_e st0,
                                       logic [RUN_WIDTH-1:0] cnt0, logic [1:0] sub0);
    beat_t                r;
    exp_state_e           s;
    logic [RUN_WIDTH-1:0] cnt;
    logic [1:0]           sub;
    r   = '0;
    s   = st0;
    cnt = cnt0;
    sub = sub0;
    for (int l = 0; l < OUT_LANES; l++) begin
      s = settle(s, cnt, sub, b);
      if (s != ST_IDLE) r.count = r.count + CW'(1);
      case (s)
        ST_HEAD: begin
          r.data[l] = b.bytes[0];
          if (b.flag inside {PLAIN1, PLAIN2, PLAIN3}) begin
            s   = ST_PLAIN;
            sub = 2'd1;
          end else begin
            s   = ST_RUN;
            cnt = b.run;
          end
        end
        ST_PLAIN: begin
          r.data[l] = (sub == 2'd1) ? b.bytes[1] : BYTE_WIDTH'(b.run);
          sub = sub + 2'd1;
        end
        ST_RUN: begin
          r.data[l] = b.bytes[1];
          cnt = cnt - RUN_WIDTH'(1);
        end
        ST_TAIL: begin
          r.data[l] = (sub == 2'd0) ? b.bytes[2] : b.bytes[3];
          sub = sub + 2'd1;
        end
        default: ;
      endcase
    end
    r.st  = settle(s, cnt, sub, b);
    r.cnt = cnt;
    r.sub = sub;
    return r;
  endfunction

  logic [AW-1:0]            wptr, rptr;
  logic [LW-1:0]            level;
  logic [$bits(bundle_t)-1:0] rdata_raw;
  bundle_t                  head, cur, push_b, src;
  exp_state_e               state, nxt_state, start_st;
  logic [RUN_WIDTH-1:0]     run_cnt, nxt_cnt, start_cnt;
  logic [1:0]               sub, nxt_sub, start_sub;
  logic                     push, pop, load, load_last, fifo_empty;
  beat_t                    walk;

  assign in_ready   = (level != LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  assign fifo_level = level;
  assign push       = in_valid & in_ready;
  assign push_b     = '{flag:  flag_e'(in_flag),
                        bytes: {in_bit_5, in_bit_4, in_bit_2, in_bit_1},
                        run:   in_bit_3,
                        last:  in_last};
  assign head       = bundle_t'(rdata_raw);

  bundle_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(bundle_t))
  ) u_fifo (
    .clk  (top_clk),
    .we   (push),
    .waddr(wptr),
    .wdata(push_b),
    .raddr(rptr),
    .rdata(rdata_raw)
  );

  // Stage p0: pick the bundle and start point, pack one beat.
  always_comb begin
    pop       = 1'b0;
    load      = 1'b0;
    nxt_state = state;
    nxt_cnt   = run_cnt;
    nxt_sub   = sub;
    if (state == ST_IDLE) begin
      src       = head;
      start_st  = is_empty_flag(head.flag) ? ST_MARK : ST_HEAD;
      start_cnt = '0;
      start_sub = '0;
    end else begin
      src       = cur;
      start_st  = state;
      start_cnt = run_cnt;
      start_sub = sub;
    end
    walk      = build_beat(src, start_st, start_cnt, start_sub);
    load_last = src.last && (walk.st == ST_IDLE);
    if (state == ST_IDLE) begin
      if (!fifo_empty && out_ready) begin
        pop       = 1'b1;
        load      = !is_empty_flag(head.flag) || head.last;
        nxt_state = walk.st;
        nxt_cnt   = walk.cnt;
        nxt_sub   = walk.sub;
      end
    end else if (!out_valid || out_ready) begin
      load      = 1'b1;
      nxt_state = walk.st;
      nxt_cnt   = walk.cnt;
      nxt_sub   = walk.sub;
    end
  end

  always_ff @(posedge top_clk) begin
    if (pop) cur <= head;
  end

  // Stage p1: FIFO pointers, FSM and registered output beat.
  always_ff @(posedge top_clk or posedge top_reset) begin
    if (top_reset) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      state     <= ST_IDLE;
      run_cnt   <= '0;
      sub       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
      state   <= nxt_state;
      run_cnt <= nxt_cnt;
      sub     <= nxt_sub;
      if (push && flag_e'(in_flag) == INVALID) err_flag <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= walk.data;
        out_count <= walk.count;
        out_last  <= load_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_expander.sv
// Directed bench: expected beats go into a scoreboard queue when stimulus is
// issued; a monitor pops and compares each accepted beat.
module tb_bitstream_expander;

  logic        top_clk = 1'b0;
  logic        top_reset;
  logic        in_valid, in_ready, in_last;
  logic [2:0]  in_flag;
  logic [7:0]  in_bit_1, in_bit_2, in_bit_3, in_bit_4, in_bit_5;
  logic        out_valid, out_ready, out_last, err_flag;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic [3:0]  fifo_level;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  count;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  bit          sb_on  = 1'b0;
  bit          hold_pend = 1'b0;
  logic [35:0] held;

  bitstream_expander #(
    .BYTE_WIDTH(8), .RUN_WIDTH(8), .FIFO_DEPTH(8), .OUT_LANES(4)
  ) dut (
    .top_clk(top_clk), .top_reset(top_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag),
    .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_bit_3(in_bit_3),
    .in_bit_4(in_bit_4), .in_bit_5(in_bit_5), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_last(out_last),
    .fifo_level(fifo_level), .err_flag(err_flag)
  );

  always #5 top_clk = ~top_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [2:0] c, input logic l);
    exp_t e;
    e.data  = d;
    e.count = c;
    e.last  = l;
    sb.push_back(e);
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [2:0] f, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                      input logic l);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b1; in_flag = f; in_last = l;
    in_bit_1 = b1; in_bit_2 = b2; in_bit_3 = b3; in_bit_4 = b4; in_bit_5 = b5;
    forever begin
      @(negedge top_clk);
      acc = in_ready;
      @(posedge top_clk);
      #1;
      if (acc) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 1000) begin
      @(posedge top_clk);
      #1;
      n++;
    end
    if (n >= 1000) check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge top_clk) begin
    exp_t e;
    if (!top_reset && sb_on) begin
      if (hold_pend) check("beat_hold", 64'({out_data, out_count, out_last}), 64'(held));
      hold_pend = out_valid && !out_ready;
      held      = {out_data, out_count, out_last};
      if (out_valid && out_ready) begin
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_beat: got data=%h count=%0d last=%0b, expected no beat",
                   out_data, out_count, out_last);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.data || out_count !== e.count || out_last !== e.last) begin
            errors = errors + 1;
            $display("FAIL beat: got data=%h count=%0d last=%0b, expected data=%h count=%0d last=%0b",
                     out_data, out_count, out_last, e.data, e.count, e.last);
          end
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    top_reset = 1'b1;
    in_valid = 1'b0; in_flag = '0; in_last = 1'b0;
    in_bit_1 = '0; in_bit_2 = '0; in_bit_3 = '0; in_bit_4 = '0; in_bit_5 = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge top_clk);
    @(negedge top_clk);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_out_count",  64'(out_count),  64'd0);
    check("rst_out_last",   64'(out_last),   64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_err_flag",   64'(err_flag),   64'd0);
    @(posedge top_clk);
    #1;
    top_reset = 1'b0;
    sb_on = 1'b1;

    // Plain 3-byte bundle and two-cycle latency.
    expect_beat(32'h0033_2211, 3'd3, 1'b0);
    send(3'd3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 1'b0);
    @(negedge top_clk);
    check("latency_n1_valid", 64'(out_valid), 64'd0);
    @(negedge top_clk);
    check("latency_n2_valid", 64'(out_valid), 64'd1);
    @(posedge top_clk);
    #1;
    drain();

    // Flag 7 across three beats with a stalling sink.
    fork
      begin
        expect_beat(32'hFFFF_FFA0, 3'd4, 1'b0);
        expect_beat(32'h01FF_FFFF, 3'd4, 1'b0);
        expect_beat(32'h0000_0002, 3'd1, 1'b1);
        send(3'd7, 8'hA0, 8'hFF, 8'd6, 8'h01, 8'h02, 1'b1);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          out_ready = (c % 3 != 2);
          @(posedge top_clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Empty run, last bundle; then a batch of mixed shapes back to back.
    expect_beat(32'h0000_0077, 3'd1, 1'b1);
    send(3'd5, 8'h77, 8'h99, 8'd0, 8'h00, 8'h00, 1'b1);
    expect_beat(32'h2020_2010, 3'd4, 1'b0);
    expect_beat(32'h0000_0030, 3'd1, 1'b0);
    send(3'd6, 8'h10, 8'h20, 8'd3, 8'h30, 8'h00, 1'b0);
    expect_beat(32'hBBBB_BBAA, 3'd4, 1'b0);
    expect_beat(32'h0000_BBBB, 3'd2, 1'b0);
    send(3'd5, 8'hAA, 8'hBB, 8'd5, 8'h00, 8'h00, 1'b0);
    expect_beat(32'h0000_3412, 3'd2, 1'b0);
    send(3'd2, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0);
    expect_beat(32'h0000_0000, 3'd0, 1'b1);
    send(3'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    expect_beat(32'h0000_00E1, 3'd1, 1'b1);
    send(3'd1, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    drain();

    // Invalid bundle is dropped and flagged.
    expect_beat(32'h0000_005A, 3'd1, 1'b0);
    send(3'd4, 8'hDE, 8'hAD, 8'd2, 8'hBE, 8'hEF, 1'b0);
    send(3'd1, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    drain();
    check("err_flag_set", 64'(err_flag), 64'd1);

    // Sink blocked while ten bundles arrive.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          expect_beat(32'(8'h40 + 8'(i)), 3'd1, 1'b0);
          send(3'd1, 8'h40 + 8'(i), 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
          if (i == 7) begin
            @(negedge top_clk);
            check("stall_fifo_level", 64'(fifo_level), 64'd8);
            check("stall_in_ready",   64'(in_ready),   64'd0);
            @(posedge top_clk);
            #1;
          end
        end
      end
      begin
        repeat (20) @(posedge top_clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("err_flag_sticky", 64'(err_flag), 64'd1);

    // Reset in the middle of a long run.
    sb_on = 1'b0;
    send(3'd5, 8'h55, 8'h66, 8'd200, 8'h00, 8'h00, 1'b0);
    repeat (10) @(posedge top_clk);
    #3;
    top_reset = 1'b1;
    #1;
    check("midrst_out_valid",  64'(out_valid),  64'd0);
    check("midrst_out_data",   64'(out_data),   64'd0);
    check("midrst_out_count",  64'(out_count),  64'd0);
    check("midrst_out_last",   64'(out_last),   64'd0);
    check("midrst_fifo_level", 64'(fifo_level), 64'd0);
    check("midrst_in_ready",   64'(in_ready),   64'd1);
    check("midrst_err_flag",   64'(err_flag),   64'd0);
    @(posedge top_clk);
    #1;
    top_reset = 1'b0;
    sb_on = 1'b1;
    expect_beat(32'h0000_C2C1, 3'd2, 1'b1);
    send(3'd2, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 1'b1);
    drain();
    repeat (5) @(posedge top_clk);
    #1;
    check("post_rst_idle_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
